regfile_mp: RTL and testbench

//  - Parametrised multi-read-port register file; next generation of the CPU integer register file.
//  - One write port and NUM_RD synchronous read ports, all on posedge clk with 1-cycle read latency.
//  - A post-reset clear sequencer zeroes one entry per cycle, so no wide single-cycle reset is needed.
//  - Sits between the decode stage (read addresses) and writeback (write port) of the core pipeline.

---
 rtl/regfile_mp.sv | 128 ++++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a post-reset clear sequencer.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       init_busy_o,
    input  logic                       w_enable_i,
    input  logic [ADDR_W-1:0]          w_addr_i,
    input  logic [DATA_W-1:0]          w_data_i,
    input  logic [NUM_RD-1:0]          rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_valid_o
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                    state_q;
    logic [ADDR_W-1:0]         ptr_q;
    logic                      busy_q;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic                      wr_ok_s;
    logic [NUM_RD*DATA_W-1:0]  rd_data_d;
    logic [NUM_RD*DATA_W-1:0]  rd_data_q;
    logic [NUM_RD-1:0]         rd_valid_d;
    logic [NUM_RD-1:0]         rd_valid_q;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // Write acceptance: only in READY, and never into a hardwired zero entry
    always_comb begin
        wr_ok_s = 1'b0;
        if ((state_q == ST_READY) && w_enable_i && !is_zero_addr(w_addr_i)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Clear sequencer: one entry per cycle, READY after the last entry is zeroed
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT;
                    ptr_q   <= {ADDR_W{1'b0}};
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: the sweep owns the write path during INIT; reset leaves contents alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_q[ptr_q] <= {DATA_W{1'b0}};
            end else if (wr_ok_s) begin
                mem_q[w_addr_i] <= w_data_i;
            end
        end
    end

    // Read-port next state: hold data when idle, zero-register rule beats forwarding
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = {NUM_RD{1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if ((state_q == ST_READY) && rd_en_i[p]) begin
                rd_valid_d[p] = 1'b1;
                if (is_zero_addr(rd_addr_i[p*ADDR_W +: ADDR_W])) begin
                    rd_data_d[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
                end else if (wr_ok_s && (w_addr_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
                    rd_data_d[p*DATA_W +: DATA_W] = w_data_i;
`endif
                end else begin
                    rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
                end
            end else begin
                rd_valid_d[p] = 1'b0;
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= {(NUM_RD*DATA_W){1'b0}};
            rd_valid_q <= {NUM_RD{1'b0}};
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign init_busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (default parameters, two read ports).
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             init_busy_o;
    logic             w_enable_i;
    logic [AW-1:0]    w_addr_i;
    logic [DW-1:0]    w_data_i;
    logic [NR-1:0]    rd_en_i;
    logic [NR*AW-1:0] rd_addr_i;
    logic [NR*DW-1:0] rd_data_o;
    logic [NR-1:0]    rd_valid_o;

    regfile_mp dut (
        .clk         (clk),
        .reset       (reset),
        .init_busy_o (init_busy_o),
        .w_enable_i  (w_enable_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_mem [DEPTH];
    logic        m_ready;
    logic [4:0]  m_ptr;
    logic [31:0] m_rd [2];
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, predict, push, then pop and compare after posedge
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [1:0] ren,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t        e;
        logic [4:0]  ra [2];
        logic [31:0] rv;
        @(negedge clk);
        reset      = rst;
        w_enable_i = we;
        w_addr_i   = wa;
        w_data_i   = wd;
        rd_en_i    = ren;
        rd_addr_i  = {ra1, ra0};
        ra[0] = ra0;
        ra[1] = ra1;
        e.valid = 2'b00;
        if (rst) begin
            m_ready = 1'b0;
            m_ptr   = 5'd0;
            m_rd[0] = 32'd0;
            m_rd[1] = 32'd0;
            e.busy  = 1'b1;
        end else if (!m_ready) begin
            m_mem[m_ptr] = 32'd0;
            if (m_ptr == 5'd31) m_ready = 1'b1;
            m_ptr  = m_ptr + 5'd1;
            e.busy = !m_ready;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ren[p]) begin
                    if (ra[p] == 5'd0) rv = 32'd0;
                    else if (BYP && we && (wa == ra[p])) rv = wd;
                    else rv = m_mem[ra[p]];
                    m_rd[p]    = rv;
                    e.valid[p] = 1'b1;
                end
            end
            if (we && (wa != 5'd0)) m_mem[wa] = wd;
            e.busy = 1'b0;
        end
        e.d0 = m_rd[0];
        e.d1 = m_rd[1];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("busy",  {31'd0, init_busy_o}, {31'd0, e.busy});
        chk("valid", {30'd0, rd_valid_o},  {30'd0, e.valid});
        chk("rd0",   rd_data_o[31:0],      e.d0);
        chk("rd1",   rd_data_o[63:32],     e.d1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    endtask

    // Counts busy samples from the last reset cycle through the sweep
    task automatic measure_busy(input string tag);
        busy_cnt = init_busy_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (init_busy_o) busy_cnt++;
        end
        chk(tag, busy_cnt, 32'd32);
    endtask

    initial begin
        reset      = 1'b1;
        w_enable_i = 1'b0;
        w_addr_i   = 5'd0;
        w_data_i   = 32'd0;
        rd_en_i    = 2'b00;
        rd_addr_i  = 10'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_ready = 1'b0;
        m_ptr   = 5'd0;
        m_rd[0] = 32'd0;
        m_rd[1] = 32'd0;

        do_reset(2);
        chk("rst_busy",  {31'd0, init_busy_o}, 32'd1);
        chk("rst_valid", {30'd0, rd_valid_o},  32'd0);
        chk("rst_data",  rd_data_o[31:0],      32'd0);
        measure_busy("busy_len");

        for (int a = 0; a < DEPTH; a += 2)
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, 5'(a), 5'(a + 1));
        chk("clr_rd1", rd_data_o[63:32], 32'd0);

        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 5'd5);
        chk("dead_p0", rd_data_o[31:0],  32'hDEADBEEF);
        chk("dead_p1", rd_data_o[63:32], 32'hDEADBEEF);
        chk("dead_v",  {30'd0, rd_valid_o}, 32'd3);

        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 5'd0, 5'd0);
        chk("zero_reg", rd_data_o[31:0], 32'd0);
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 2'b10, 5'd0, 5'd0);
        chk("zero_byp", rd_data_o[63:32], 32'd0);

        cycle(1'b0, 1'b1, 5'd7, 32'h00000001, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 2'b01, 5'd7, 5'd0);
        chk("same_cyc", rd_data_o[31:0], BYP ? 32'hA5A5A5A5 : 32'h00000001);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0);
        chk("after_wr", rd_data_o[31:0], 32'hA5A5A5A5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 5'd5, 5'd0);
        chk("hold_d", rd_data_o[31:0], 32'hA5A5A5A5);
        chk("hold_v", {30'd0, rd_valid_o}, 32'd0);

        cycle(1'b0, 1'b1, 5'd9, 32'h00000055, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b10, 5'd0, 5'd9);
        chk("a9_set", rd_data_o[63:32], 32'h00000055);
        do_reset(1);
        idle(10);
        do_reset(1);
        measure_busy("busy_rerun");
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 5'd0);
        chk("a9_clr", rd_data_o[31:0], 32'd0);

        do_reset(2);
        idle(3);
        cycle(1'b0, 1'b1, 5'd3, 32'h000000FF, 2'b11, 5'd3, 5'd3);
        chk("init_rdv", {30'd0, rd_valid_o}, 32'd0);
        for (int i = 0; i < 40 && init_busy_o; i++) idle(1);
        chk("ready_to", {31'd0, init_busy_o}, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 5'd3, 5'd0);
        chk("init_wr", rd_data_o[31:0], 32'd0);

        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
